// File: rtl/hsv_core_stream_serializer_pkg.sv
// +--------------------------------------------------------------------+
// | hsv_core_stream_serializer_pkg                                     |
// | Shared defaults for the stream serializer and its helpers.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package hsv_core_stream_serializer_pkg;

  localparam int DEF_LANES      = 4;
  localparam int DEF_LANE_WIDTH = 32;
  localparam int DEF_PRIO_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/hsv_core_prio_onehot.sv
// +--------------------------------------------------------------------+
// | hsv_core_prio_onehot                                               |
// | One-hot grant of the lowest set bit of a request vector.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hsv_core_prio_onehot
  import hsv_core_stream_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_PRIO_WIDTH
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit; zero in gives zero out.
  assign grant = req & (~req + WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/hsv_core_stream_serializer.sv
// +--------------------------------------------------------------------+
// | hsv_core_stream_serializer                                         |
// | Masked multi-lane word to single-lane stream, one lane per cycle.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hsv_core_stream_serializer
  import hsv_core_stream_serializer_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
  input  logic                        clk_core,
  input  logic                        rst_core,
  input  logic                        flush,
  output logic                        ready_o,
  input  logic                        valid_i,
  input  logic [LANES*LANE_WIDTH-1:0] in,
  input  logic [LANES-1:0]            in_mask,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [LANE_WIDTH-1:0]       out,
  output logic                        last_o
);

  logic [LANES*LANE_WIDTH-1:0] r_word;
  logic [LANES-1:0]            r_mask;
  logic [LANES-1:0]            w_sel;
  logic                        w_valid;
  logic                        w_last;
  logic                        w_ready;
  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic [LANE_WIDTH-1:0]       w_terms [LANES];
  logic [LANE_WIDTH-1:0]       w_out;

  hsv_core_prio_onehot #(
    .WIDTH (LANES)
  ) u_prio (
    .req   (r_mask),
    .grant (w_sel)
  );

  assign w_valid    = |r_mask;
  // A mask holds exactly one bit when it equals its own lowest set bit.
  assign w_last     = w_valid && (w_sel == r_mask);
  assign w_ready    = !w_valid || (w_last && ready_i);
  assign w_in_xfer  = w_ready && valid_i;
  assign w_out_xfer = w_valid && ready_i;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_terms[k] = {LANE_WIDTH{w_sel[k]}} & r_word[k*LANE_WIDTH +: LANE_WIDTH];
    end
  endgenerate

  always_comb begin
    w_out = '0;
    for (int k = 0; k < LANES; k++) begin
      w_out = w_out | w_terms[k];
    end
  end

  // Flush beats both transfers; a new word overrides draining of the last lane.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_mask <= '0;
    end else if (flush) begin
      r_mask <= '0;
    end else if (w_in_xfer) begin
      r_mask <= in_mask;
    end else if (w_out_xfer) begin
      r_mask <= r_mask & ~w_sel;
    end
  end

  always_ff @(posedge clk_core) begin
    if (w_in_xfer) begin
      r_word <= in;
    end
  end

  assign ready_o = w_ready;
  assign valid_o = w_valid;
  assign last_o  = w_last;
  assign out     = w_out;

endmodule

`default_nettype wire

// File: tb/tb_hsv_core_stream_serializer.sv
// +--------------------------------------------------------------------+
// | tb_hsv_core_stream_serializer                                      |
// | Directed vector bench for the stream serializer (4 x 8-bit lanes). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hsv_core_stream_serializer;

  localparam int LANES = 4;
  localparam int LW    = 8;

  logic             clk_core = 1'b0;
  logic             rst_core = 1'b1;
  logic             flush    = 1'b0;
  logic             ready_o;
  logic             valid_i  = 1'b0;
  logic [LANES*LW-1:0] in    = '0;
  logic [LANES-1:0] in_mask  = '0;
  logic             ready_i  = 1'b0;
  logic             valid_o;
  logic [LW-1:0]    out;
  logic             last_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        vld;
    logic [31:0] din;
    logic [3:0]  msk;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [7:0]  e_out;
    logic        e_last;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  hsv_core_stream_serializer #(
    .LANES      (LANES),
    .LANE_WIDTH (LW)
  ) dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .flush    (flush),
    .ready_o  (ready_o),
    .valid_i  (valid_i),
    .in       (in),
    .in_mask  (in_mask),
    .ready_i  (ready_i),
    .valid_o  (valid_o),
    .out      (out),
    .last_o   (last_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [31:0] din, input logic [3:0] msk,
                              input logic rdy, input logic fl, input logic e_valid,
                              input logic [7:0] e_out, input logic e_last, input logic e_ready);
    vec_t v;
    v.vld = vld; v.din = din; v.msk = msk; v.rdy = rdy; v.fl = fl;
    v.e_valid = e_valid; v.e_out = e_out; v.e_last = e_last; v.e_ready = e_ready;
    return v;
  endfunction

  task automatic drive(input logic vld, input logic [31:0] din, input logic [3:0] msk,
                       input logic rdy, input logic fl);
    valid_i = vld; in = din; in_mask = msk; ready_i = rdy; flush = fl;
  endtask

  initial begin
    // Single word, all lanes
    vecs.push_back(mk(1, 32'h44332211, 4'b1111, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h22, 0, 0));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h33, 0, 0));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h44, 1, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 1));
    // Back-to-back: A mask 1010 then B mask 0001 with no bubble
    vecs.push_back(mk(1, 32'hD4C3B2A1, 4'b1010, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(1, 32'h0000005A, 4'b0001, 1, 0, 1, 8'hB2, 0, 0));
    vecs.push_back(mk(1, 32'h0000005A, 4'b0001, 1, 0, 1, 8'hD4, 1, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h5A, 1, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 1));
    // Zero-mask word followed by a single-lane word
    vecs.push_back(mk(1, 32'h99887766, 4'b0000, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(1, 32'h00770000, 4'b0100, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h77, 1, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 1));
    // Stall three cycles on the last lane while another word waits upstream
    vecs.push_back(mk(1, 32'h00CCBBAA, 4'b0111, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'hAA, 0, 0));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'hBB, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, 4'b1111, 0, 0, 1, 8'hCC, 1, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, 4'b1111, 0, 0, 1, 8'hCC, 1, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, 4'b1111, 0, 0, 1, 8'hCC, 1, 0));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'hCC, 1, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 1));
    // Flush coinciding with both an input and an output transfer
    vecs.push_back(mk(1, 32'h04030201, 4'b0011, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 1, 8'h01, 0, 0));
    vecs.push_back(mk(1, 32'h08070605, 4'b1111, 1, 1, 1, 8'h02, 1, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 1));

    // Reset state, observed while reset is still asserted
    #2;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset last_o",  32'(last_o),  32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    #1 rst_core = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk_core);
      #1 drive(vecs[i].vld, vecs[i].din, vecs[i].msk, vecs[i].rdy, vecs[i].fl);
      #3;
      check($sformatf("row%0d valid_o", i), 32'(valid_o), 32'(vecs[i].e_valid));
      check($sformatf("row%0d last_o",  i), 32'(last_o),  32'(vecs[i].e_last));
      check($sformatf("row%0d ready_o", i), 32'(ready_o), 32'(vecs[i].e_ready));
      if (vecs[i].e_valid)
        check($sformatf("row%0d out", i), 32'(out), 32'(vecs[i].e_out));
    end

    // Asynchronous reset pulsed between edges in the middle of a word
    @(posedge clk_core);
    #1 drive(1, 32'hDDCCBBAA, 4'b1111, 1, 0);
    #3 check("arst accept ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_core);
    #1 drive(0, 32'h0, 4'b0000, 1, 0);
    #3;
    check("arst pre valid_o", 32'(valid_o), 32'd1);
    check("arst pre out",     32'(out),     32'hAA);
    #2 rst_core = 1'b1;
    #1;
    check("arst valid_o", 32'(valid_o), 32'd0);
    check("arst last_o",  32'(last_o),  32'd0);
    check("arst ready_o", 32'(ready_o), 32'd1);
    #1 rst_core = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_core);
      #4;
      check($sformatf("arst post%0d valid_o", c), 32'(valid_o), 32'd0);
      check($sformatf("arst post%0d ready_o", c), 32'(ready_o), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
